// File: rtl/park_slot_allocator_pkg.sv
// Shared types and defaults for the parking slot allocator.
package park_slot_allocator_pkg;

  localparam int unsigned SLOTS_DEFAULT       = 8;
  localparam int unsigned GATE_CYCLES_DEFAULT = 4;
  localparam int unsigned OCC_W               = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMMIT  = 3'd1,
    ST_REJECT  = 3'd2,
    ST_GATE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  function automatic logic [OCC_W-1:0] slot_onehot(input logic [2:0] idx);
    logic [OCC_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/park_slot_allocator_free_slot_finder.sv
// Priority encoder: lowest-index free (zero) bit of the occupancy bitmap.
module free_slot_finder
  import park_slot_allocator_pkg::*;
#(
  parameter int unsigned SLOTS = SLOTS_DEFAULT
) (
  input  logic [SLOTS-1:0] occupancy,
  output logic             found,
  output logic [2:0]       index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!occupancy[i] && !found) begin
        found = 1'b1;
        index = i[2:0];
      end
    end
  end

endmodule

// File: rtl/park_slot_allocator.sv
// Entry/exit slot allocation controller owning the parking occupancy bitmap.
module park_slot_allocator
  import park_slot_allocator_pkg::*;
#(
  parameter int unsigned SLOTS       = SLOTS_DEFAULT,
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  input  logic [7:0] new_capacity,
  output logic [7:0] park_location,
  output logic [7:0] parking_capacity,
  output logic [2:0] assigned_slot,
  output logic       req_ack,
  output logic       req_reject,
  output logic       gate_open,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic [3:0] free_count,
  output logic       cap_mismatch
);

  state_e     state_q, state_d;
  logic [2:0] target_q, target_d;
  logic [7:0] cap_q, cap_d;
  logic [2:0] assigned_q, assigned_d;
  logic [3:0] gate_cnt_q, gate_cnt_d;
  logic       mismatch_q, mismatch_d;

  logic       free_found;
  logic [2:0] free_idx;

  free_slot_finder #(
    .SLOTS(SLOTS)
  ) u_finder (
    .occupancy(cap_q),
    .found    (free_found),
    .index    (free_idx)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cap_d      = cap_q;
    assigned_d = assigned_q;
    gate_cnt_d = gate_cnt_q;
    mismatch_d = mismatch_q;

    case (state_q)
      ST_IDLE: begin
        if (exit_req) begin
          target_d = exit_slot;
          if (cap_q[exit_slot]) begin
            state_d    = ST_COMMIT;
            assigned_d = exit_slot;
          end else begin
            state_d = ST_REJECT;
          end
        end else if (entry_req) begin
          target_d = free_idx;
          if (free_found) begin
            state_d    = ST_COMMIT;
            assigned_d = free_idx;
          end else begin
            state_d = ST_REJECT;
          end
        end
      end
      ST_COMMIT: begin
        cap_d      = new_capacity;
        gate_cnt_d = 4'(GATE_CYCLES);
        if (new_capacity != (cap_q ^ park_location)) begin
          mismatch_d = 1'b1;
        end
        state_d = ST_GATE;
      end
      ST_REJECT: state_d = ST_RELEASE;
      ST_GATE: begin
        if (gate_cnt_q <= 4'd1) begin
          state_d = ST_RELEASE;
        end else begin
          gate_cnt_d = gate_cnt_q - 4'd1;
        end
      end
      ST_RELEASE: begin
        if (!entry_req && !exit_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      cap_q      <= '0;
      assigned_q <= '0;
      gate_cnt_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cap_q      <= cap_d;
      assigned_q <= assigned_d;
      gate_cnt_q <= gate_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    free_count = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      free_count = free_count + {3'b000, ~cap_q[i]};
    end
  end

  // Handshake outputs decode straight from state so reset clears them asynchronously.
  assign park_location    = (state_q == ST_COMMIT) ? slot_onehot(target_q) : '0;
  assign parking_capacity = cap_q;
  assign assigned_slot    = assigned_q;
  assign req_ack          = (state_q == ST_COMMIT);
  assign req_reject       = (state_q == ST_REJECT);
  assign gate_open        = (state_q == ST_GATE);
  assign busy             = (state_q != ST_IDLE);
  assign full             = &cap_q;
  assign empty            = ~|cap_q;
  assign cap_mismatch     = mismatch_q;

endmodule

// File: tb/tb_park_slot_allocator.sv
// Self-checking bench for park_slot_allocator against a bitmap reference model.
module tb_park_slot_allocator;

  logic       clk, rst_n, entry_req, exit_req;
  logic [2:0] exit_slot;
  logic [7:0] new_capacity, park_location, parking_capacity;
  logic [2:0] assigned_slot;
  logic       req_ack, req_reject, gate_open, busy, full, empty, cap_mismatch;
  logic [3:0] free_count;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   corrupt   = 0;
  logic [7:0] m_cap;
  logic [2:0] m_assigned;
  bit         m_mismatch;

  park_slot_allocator #(.SLOTS(8), .GATE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .new_capacity(new_capacity), .park_location(park_location),
    .parking_capacity(parking_capacity), .assigned_slot(assigned_slot),
    .req_ack(req_ack), .req_reject(req_reject), .gate_open(gate_open), .busy(busy),
    .full(full), .empty(empty), .free_count(free_count), .cap_mismatch(cap_mismatch)
  );

  // Downstream calculate_new_capacity stage, optionally corrupted.
  assign new_capacity = parking_capacity ^ park_location ^ (corrupt ? 8'h80 : 8'h00);

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int model_free(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!m[i]) n++;
    return n;
  endfunction

  task automatic transact(input bit ex, input bit en, input logic [2:0] slot, input string tag);
    bit accept; logic [2:0] tgt; logic [7:0] exp_pl; int gcnt;
    accept = 0; tgt = 0;
    if (ex) begin accept = m_cap[slot]; tgt = slot; end
    else if (en) begin
      for (int i = 7; i >= 0; i--) if (!m_cap[i]) begin accept = 1; tgt = 3'(i); end
    end
    exp_pl = accept ? (8'h01 << tgt) : 8'h00;
    exit_req = ex; entry_req = en; exit_slot = slot;
    @(posedge clk); @(negedge clk);
    total_cnt++; if (req_ack !== accept) $display("FAIL %s ack: got %b want %b", tag, req_ack, accept); else pass_cnt++;
    total_cnt++; if (req_reject !== !accept) $display("FAIL %s reject: got %b want %b", tag, req_reject, !accept); else pass_cnt++;
    total_cnt++; if (park_location !== exp_pl) $display("FAIL %s park_location: got %h want %h", tag, park_location, exp_pl); else pass_cnt++;
    if (accept) begin
      m_assigned = tgt;
      total_cnt++; if (assigned_slot !== tgt) $display("FAIL %s assigned_slot: got %0d want %0d", tag, assigned_slot, tgt); else pass_cnt++;
      m_cap = m_cap ^ exp_pl ^ (corrupt ? 8'h80 : 8'h00);
      if (corrupt) m_mismatch = 1;
      @(negedge clk);
      total_cnt++; if (parking_capacity !== m_cap) $display("FAIL %s capacity: got %h want %h", tag, parking_capacity, m_cap); else pass_cnt++;
      total_cnt++; if (park_location !== 8'h00) $display("FAIL %s park_location_after: got %h want 00", tag, park_location); else pass_cnt++;
      gcnt = 0;
      while (gate_open === 1'b1 && gcnt < 20) begin gcnt++; @(negedge clk); end
      total_cnt++; if (gcnt != 4) $display("FAIL %s gate_cycles: got %0d want 4", tag, gcnt); else pass_cnt++;
    end else begin
      @(negedge clk);
      total_cnt++; if (gate_open !== 1'b0) $display("FAIL %s gate_on_reject: got %b want 0", tag, gate_open); else pass_cnt++;
      total_cnt++; if (parking_capacity !== m_cap) $display("FAIL %s capacity_unchanged: got %h want %h", tag, parking_capacity, m_cap); else pass_cnt++;
      total_cnt++; if (assigned_slot !== m_assigned) $display("FAIL %s assigned_held: got %0d want %0d", tag, assigned_slot, m_assigned); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL %s release_hold: busy got %b want 1", tag, busy); else pass_cnt++;
    entry_req = 0; exit_req = 0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL %s back_to_idle: busy got %b want 0", tag, busy); else pass_cnt++;
    total_cnt++; if (free_count !== 4'(model_free(m_cap))) $display("FAIL %s free_count: got %0d want %0d", tag, free_count, model_free(m_cap)); else pass_cnt++;
    total_cnt++; if (full !== (m_cap == 8'hFF)) $display("FAIL %s full: got %b want %b", tag, full, m_cap == 8'hFF); else pass_cnt++;
    total_cnt++; if (empty !== (m_cap == 8'h00)) $display("FAIL %s empty: got %b want %b", tag, empty, m_cap == 8'h00); else pass_cnt++;
    total_cnt++; if (cap_mismatch !== m_mismatch) $display("FAIL %s cap_mismatch: got %b want %b", tag, cap_mismatch, m_mismatch); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 0; entry_req = 0; exit_req = 0; exit_slot = 0;
    m_cap = 0; m_assigned = 0; m_mismatch = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total_cnt++; if (parking_capacity !== 8'h00) $display("FAIL reset capacity: got %h want 00", parking_capacity); else pass_cnt++;
    total_cnt++; if (park_location !== 8'h00) $display("FAIL reset park_location: got %h want 00", park_location); else pass_cnt++;
    total_cnt++; if ({req_ack, req_reject, gate_open, busy, cap_mismatch} !== 5'b0) $display("FAIL reset flags: got %b want 00000", {req_ack, req_reject, gate_open, busy, cap_mismatch}); else pass_cnt++;
    total_cnt++; if ({empty, full} !== 2'b10) $display("FAIL reset empty_full: got %b want 10", {empty, full}); else pass_cnt++;
    total_cnt++; if (free_count !== 4'd8) $display("FAIL reset free_count: got %0d want 8", free_count); else pass_cnt++;
    total_cnt++; if (assigned_slot !== 3'd0) $display("FAIL reset assigned_slot: got %0d want 0", assigned_slot); else pass_cnt++;
  endtask

  task automatic test_first_entry();
    transact(0, 1, 0, "first_entry");
  endtask

  task automatic test_lowest_free();
    transact(0, 1, 0, "fill_slot1");
    transact(0, 1, 0, "fill_slot2");
    transact(0, 1, 0, "entry_on_07");
  endtask

  task automatic test_exit();
    transact(1, 0, 3'd2, "exit_slot2");
    transact(1, 0, 3'd6, "exit_empty_slot6");
  endtask

  task automatic test_full_reject();
    for (int i = 0; i < 5; i++) transact(0, 1, 0, "fill_to_full");
    total_cnt++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else pass_cnt++;
    transact(0, 1, 0, "entry_when_full");
  endtask

  task automatic test_simultaneous();
    test_reset();
    transact(0, 1, 0, "simul_setup");
    transact(1, 1, 3'd0, "simul_exit_first");
    transact(0, 1, 0, "simul_entry_after");
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      transact(op != 0, op != 1, 3'($urandom_range(0, 7)), "random");
    end
  endtask

  task automatic test_mismatch();
    corrupt = 1;
    transact(0, 1, 0, "mismatch_commit");
    corrupt = 0;
    transact(1, 0, 3'($urandom_range(0, 7)), "mismatch_sticky");
  endtask

  task automatic test_reset_mid_gate();
    int guard = 0;
    entry_req = 1;
    while (gate_open !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    total_cnt++; if (gate_open !== 1'b1) $display("FAIL midgate_reach_gate: got %b want 1", gate_open); else pass_cnt++;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    total_cnt++; if (gate_open !== 1'b0) $display("FAIL midgate_gate_closed: got %b want 0", gate_open); else pass_cnt++;
    total_cnt++; if (parking_capacity !== 8'h00) $display("FAIL midgate_capacity: got %h want 00", parking_capacity); else pass_cnt++;
    total_cnt++; if (cap_mismatch !== 1'b0) $display("FAIL midgate_mismatch_cleared: got %b want 0", cap_mismatch); else pass_cnt++;
    entry_req = 0;
    @(negedge clk);
    rst_n = 1;
    m_cap = 0; m_assigned = 0; m_mismatch = 0;
    @(negedge clk);
    transact(0, 1, 0, "after_midgate_reset");
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_lowest_free();
    test_exit();
    test_full_reject();
    test_simultaneous();
    test_random();
    test_mismatch();
    test_reset_mid_gate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
